// File: rtl/mdu_sched.sv
// mdu_sched: multi-cycle MIPS multiply/divide scheduler owning HI/LO.
// Optional MADD/MADDU (ops 6/7) enabled by defining MDU_MADD_EN.
module mdu_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  MDUop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  output logic        Busy,
  output logic        Stall,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
`ifdef MDU_MADD_EN
  localparam logic MADD = 1'b1;
`else
  localparam logic MADD = 1'b0;
`endif
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, load;
  logic [31:0] ph, pl, na, nb, q, r;
  logic [63:0] ax, bx, prod, acc, dres, res;
  logic counted, issue, mt, is_div, sgn, fin;
  always_comb begin
    counted = ~MDUop[2] | (MADD & MDUop[2] & MDUop[1]);
    issue   = (state == IDLE) & Start & ~Req & counted;
    mt      = (state == IDLE) & Start & ~Req & (MDUop[2:1] == 2'b10);
    is_div  = MDUop[2:1] == 2'b01;
    sgn     = ~MDUop[0];
    fin     = (state == RUN) & (cnt == '0);
    load    = is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
  end
  // Sign-extend to 64 bits so one multiplier serves signed and unsigned ops.
  always_comb begin
    ax   = {{32{sgn & A[31]}}, A};
    bx   = {{32{sgn & B[31]}}, B};
    prod = ax * bx;
    acc  = MDUop[2] ? {HI, LO} + prod : prod;
  end
  // Divide on magnitudes, then fix signs: quotient truncates toward zero,
  // remainder follows the dividend; this also makes 0x80000000/-1 wrap cleanly.
  always_comb begin
    na   = (sgn & A[31]) ? -A : A;
    nb   = (sgn & B[31]) ? -B : B;
    q    = nb == '0 ? '0 : na / nb;
    r    = nb == '0 ? '0 : na % nb;
    dres = {(sgn & A[31]) ? -r : r, (sgn & (A[31] ^ B[31])) ? -q : q};
    res  = is_div ? (B == '0 ? {HI, LO} : dres) : acc;
  end
  always_ff @(posedge Clk)
    if (Reset) state <= IDLE;
    else state <= state_d;
  always_comb
    state_d = state == IDLE ? (issue ? RUN : IDLE) : (cnt == '0 ? IDLE : RUN);
  always_comb begin
    Busy  = state == RUN;
    Stall = Busy | (Start & ~Req & counted);
  end
  always_ff @(posedge Clk)
    if (Reset) begin
      cnt  <= '0;
      ph   <= '0;
      pl   <= '0;
      Done <= 1'b0;
      HI   <= '0;
      LO   <= '0;
    end else begin
      Done <= fin;
      cnt  <= issue ? load : (state == RUN ? cnt - 1'b1 : cnt);
      if (issue) {ph, pl} <= res;
      if (fin) {HI, LO} <= {ph, pl};
      else if (mt && MDUop[0]) LO <= A;
      else if (mt) HI <= A;
    end
endmodule

// File: doc/mdu_sched.md
Name: mdu_sched

Overview:
- Multi-cycle multiply/divide scheduler for the MIPS datapath, placed beside the ALU in the execute stage.
- Accepts one MDU operation per start pulse, holds the operands and a latency counter, and raises Busy/Stall so the front end freezes until HI/LO are valid.
- Owns the HI/LO architectural registers, serves MTHI/MTLO writes, and drops starts cancelled by a CP0 exception request.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD/MADDU when enabled); must be ≥1.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; must be ≥1.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  issue strobe for MDUop this cycle.
- MDUop  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU.
- A  input  32  rs operand.
- B  input  32  rt operand.
- Req  input  1  CP0 exception/interrupt request; cancels the same-cycle Start.
- Busy  output  1  registered; high while a mult/div is in flight.
- Stall  output  1  combinational: Busy | (Start & ~Req & MDUop is a counted op).
- Done  output  1  registered one-cycle pulse on the edge that commits HI/LO.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset (synchronous, active-high): state IDLE, counter 0, Busy 0, Done 0, HI 0, LO 0. Reset mid-operation aborts the op; HI/LO are not committed.
- FSM states: IDLE, RUN.
  - IDLE → RUN: on an edge with Start=1, Req=0, MDUop ∈ {0,1,2,3} (plus {6,7} with the optional feature). At that edge, compute the result into pending regs PH/PL and load counter = N−1, where N is MULT_CYCLES or DIV_CYCLES. Busy goes 1 the next cycle.
  - RUN: decrement counter each edge. On the edge where counter==0: HI←PH, LO←PL, Done←1 for one cycle, Busy←0, back to IDLE.
  - Busy is high for exactly N cycles, starting the cycle after Start. New HI/LO values are visible the cycle after Busy falls.
- MTHI/MTLO (op 4/5): in IDLE with Req=0, write HI←A or LO←A at the edge. Busy does not rise; Stall is 0.
- Start while in RUN: ignored; state and HI/LO unaffected. The pipeline must hold via Stall.
- Start with Req=1: suppressed entirely (no state change, no HI/LO write).
- Req during RUN: no effect. An issued op always completes and commits.
- Arithmetic:
  - MULT: signed 32×32 → 64, HI=[63:32], LO=[31:0].
  - MULTU: unsigned 32×32 → 64, same split.
  - DIV: signed; LO = quotient truncated toward zero; HI = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: unsigned; LO = quotient, HI = remainder.
  - Divide by zero (B==0): still runs DIV_CYCLES; HI/LO keep their prior values; Done still pulses.
- Undefined ops (6/7 without the optional feature): no effect, Stall 0.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: ops 6 (MADD, signed) and 7 (MADDU, unsigned) compute {HI,LO} + A×B (64-bit, wrap modulo 2^64), using the HI/LO values current at issue, with MULT_CYCLES latency. Stall and Busy behave exactly as for MULT.
- Undefined: ops 6/7 are no-ops, identical to other undefined ops.

Test Plan:
- MULT A=0xFFFFFFFE (−2), B=3 → Busy high for 5 cycles starting the cycle after Start; then HI=0xFFFFFFFF, LO=0xFFFFFFFA, Done pulses once.
- DIV A=0xFFFFFFF9 (−7), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU A=7, B=2 → LO=3, HI=1.
- DIVU with B=0 after MTHI 0x1234 and MTLO 0x5678 → 10 busy cycles, Done pulses, HI=0x1234, LO=0x5678 unchanged.
- Start MULTU A=B=0xFFFFFFFF with Req=1 → Busy stays 0, Stall 0, HI/LO unchanged. Repeat with Req=0 → HI=0xFFFFFFFE, LO=0x00000001.
- During a MULT, issue Start MTLO with A=0xAAAA at busy cycle 2 and assert Reset at busy cycle 3 (second run) → first run: MTLO ignored, MULT result committed. Second run: HI/LO=0, Busy=0 the cycle after reset.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then MADDU A=1, B=1 → HI=1, LO=0 after 5 cycles. Without the macro: same stimulus leaves HI/LO unchanged and Busy 0.
